vc_skid_reg: RTL and testbench

// - Registered val/rdy pipeline stage: cuts the forward path (val, msg) and the backward path (rdy).
// - Complements the enable-driven vc_*Reg family. Those registers are loaded by their writer; this

---
 rtl/vc_skid_reg.sv | 104 ++++++++++
 tb/tb_vc_skid_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vc_skid_reg.sv
// Two-entry registered val/rdy stage (main + skid) that cuts both the forward and backward paths.
// Optional stall statistics are enabled by defining VC_SKID_REG_STATS_EN.
module vc_skid_reg #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg
`ifdef VC_SKID_REG_STATS_EN
  ,
  output logic [p_cnt_nbits-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [p_nbits-1:0] skid;

  // out_msg is the main register itself; in_rdy and out_val are registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= EMPTY;
      out_val <= 1'b0;
      in_rdy  <= 1'b1;
      out_msg <= '0;
      skid    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_val) begin
            state   <= ONE;
            out_msg <= in_msg;
            out_val <= 1'b1;
            in_rdy  <= 1'b1;
          end
        end
        ONE: begin
          if (in_val && out_rdy) begin
            out_msg <= in_msg;
          end else if (in_val && !out_rdy) begin
            state  <= FULL;
            skid   <= in_msg;
            in_rdy <= 1'b0;
          end else if (!in_val && out_rdy) begin
            state   <= EMPTY;
            out_val <= 1'b0;
          end
        end
        FULL: begin
          if (out_rdy) begin
            state   <= ONE;
            out_msg <= skid;
            in_rdy  <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          out_val <= 1'b0;
          in_rdy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef VC_SKID_REG_STATS_EN
  // Saturating count of cycles where a valid message is held back by the consumer
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (out_val && !out_rdy && (stall_count != {p_cnt_nbits{1'b1}})) begin
      stall_count <= stall_count + p_cnt_nbits'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  if (p_nbits < 1 || p_cnt_nbits < 1) begin : g_bad_params
    $error("vc_skid_reg: p_nbits and p_cnt_nbits must be at least 1");
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown({in_val, out_rdy}))
        else $error("vc_skid_reg: in_val or out_rdy is X");
      if (in_val && in_rdy) begin
        assert (!$isunknown(in_msg))
          else $error("vc_skid_reg: in_msg is X on a transfer");
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_skid_reg.sv
// Self-checking bench for vc_skid_reg: directed steps plus random val/rdy traffic against a queue model.
// Define VC_SKID_REG_STATS_EN to also check the saturating stall counter (built with p_cnt_nbits=3).
module tb_vc_skid_reg;

`ifdef VC_SKID_REG_STATS_EN
  localparam int unsigned CntBits = 3;
`else
  localparam int unsigned CntBits = 16;
`endif
  localparam int unsigned CntMax = (1 << CntBits) - 1;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
`ifdef VC_SKID_REG_STATS_EN
  logic [CntBits-1:0] stall_count;
`endif

  vc_skid_reg #(
    .p_nbits    (32),
    .p_cnt_nbits(CntBits)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg)
`ifdef VC_SKID_REG_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // The stage is modelled as a FIFO of depth two; out_msg shows the most recent head
  logic [31:0] q[$];
  logic [31:0] last_head = '0;
  int unsigned stall = 0;
  int unsigned delivered = 0;
  int unsigned accepted = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_edge();
    bit do_pop;
    bit do_push;
    if (!reset) begin
      q.delete();
      last_head = '0;
      stall = 0;
    end else begin
      do_pop  = (q.size() > 0) && out_rdy;
      do_push = in_val && (q.size() < 2);
      if ((q.size() > 0) && !out_rdy && (stall < CntMax)) stall++;
      if (do_pop) begin
        void'(q.pop_front());
        delivered++;
      end
      if (do_push) begin
        q.push_back(in_msg);
        accepted++;
      end
      if (q.size() > 0) last_head = q[0];
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".out_val"}, 64'(out_val), 64'(q.size() > 0));
    check({tag, ".in_rdy"}, 64'(in_rdy), 64'(q.size() < 2));
    check({tag, ".out_msg"}, 64'(out_msg), 64'(last_head));
`ifdef VC_SKID_REG_STATS_EN
    check({tag, ".stall_count"}, 64'(stall_count), 64'(stall));
`endif
  endtask

  task automatic apply_stimulus(input string tag, input logic rst, input logic v,
                                input logic [31:0] m, input logic r);
    reset   = rst;
    in_val  = v;
    in_msg  = m;
    out_rdy = r;
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = 1'b1;
    in_msg  = 32'hDEAD_BEEF;
    out_rdy = 1'b0;

    $display("[TB] reset with in_val high");
    for (int i = 0; i < 2; i++) apply_stimulus("reset", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("reset.out_val_const", 64'(out_val), 64'd0);
    check("reset.in_rdy_const", 64'(in_rdy), 64'd1);
    check("reset.out_msg_const", 64'(out_msg), 64'd0);

    $display("[TB] streaming 0x01..0x10");
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus("stream", 1'b1, 1'b1, 32'(i), 1'b1);
      check("stream.latency", 64'(out_msg), 64'(i));
      check("stream.in_rdy_const", 64'(in_rdy), 64'd1);
    end
    apply_stimulus("stream_drain", 1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] backpressure");
    apply_stimulus("bp_a", 1'b1, 1'b1, 32'hA, 1'b0);
    apply_stimulus("bp_b", 1'b1, 1'b1, 32'hB, 1'b0);
    check("bp.full_in_rdy", 64'(in_rdy), 64'd0);
    check("bp.full_head", 64'(out_msg), 64'hA);
    apply_stimulus("bp_hold", 1'b1, 1'b1, 32'h77, 1'b0);
    check("bp.hold_head", 64'(out_msg), 64'hA);
    apply_stimulus("bp_rel1", 1'b1, 1'b0, 32'h0, 1'b1);
    check("bp.second_out", 64'(out_msg), 64'hB);
    check("bp.in_rdy_back", 64'(in_rdy), 64'd1);
    apply_stimulus("bp_rel2", 1'b1, 1'b0, 32'h0, 1'b1);
    check("bp.drained", 64'(out_val), 64'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus("rand", 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) apply_stimulus("rand_drain", 1'b1, 1'b0, 32'h0, 1'b1);
    check("rand.no_loss", 64'(delivered), 64'(accepted));

    $display("[TB] mid-operation reset");
    apply_stimulus("mid_c", 1'b1, 1'b1, 32'hC, 1'b0);
    apply_stimulus("mid_d", 1'b1, 1'b1, 32'hD, 1'b0);
    check("mid.full", 64'(in_rdy), 64'd0);
    apply_stimulus("mid_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    check("mid.out_val_const", 64'(out_val), 64'd0);
    check("mid.in_rdy_const", 64'(in_rdy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("mid_after", 1'b1, 1'b0, 32'h0, 1'b1);
      check("mid.no_ghost", 64'(out_val), 64'd0);
    end

`ifdef VC_SKID_REG_STATS_EN
    $display("[TB] stall counter");
    apply_stimulus("stat_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus("stat_load", 1'b1, 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus("stat_stall", 1'b1, 1'b0, 32'h0, 1'b0);
    check("stat.five", 64'(stall_count), 64'd5);
    for (int i = 0; i < 5; i++) apply_stimulus("stat_sat", 1'b1, 1'b0, 32'h0, 1'b0);
    check("stat.saturate", 64'(stall_count), 64'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
